// File: rtl/sppm_pulse_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sppm_pulse_gen
// Description : SPPM transmit pulse train with programmable interval, optional
//               LFSR jitter, and a per-window count of emitted pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sppm_pulse_gen #(
    parameter int          WIDTH_CYC = 80,
    parameter int          DEAD_CYC  = 40,
    parameter int          MS_CYC    = 400000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk400M,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] period,
    input  logic        rand_en,
    input  logic [3:0]  rand_shift,
    output logic        sppm_out,
    output logic        pulse_start,
    output logic        busy,
    output logic [16:0] cnt_1ms,
    output logic        cnt_valid
);

    localparam logic [15:0] c_SEED     = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [20:0] c_WIDTH    = 21'(WIDTH_CYC);
    localparam logic [20:0] c_MIN_IV   = 21'(WIDTH_CYC + DEAD_CYC);
    localparam int          c_WW       = $clog2(MS_CYC);
    localparam logic [c_WW-1:0] c_WIN_LAST = c_WW'(MS_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [20:0]       r_cnt;
    logic [20:0]       r_interval;
    logic [15:0]       r_lfsr;
    logic              r_out;
    logic              r_pulse_start;
    logic [c_WW-1:0]   r_win;
    logic [16:0]       r_pcount;
    logic [16:0]       r_cnt_1ms;
    logic              r_cnt_valid;

    logic              w_rise;
    logic              w_fall;
    logic              w_win_end;
    logic [15:0]       w_mask;
    logic [20:0]       w_raw;
    logic [20:0]       w_interval;
    logic [15:0]       w_lfsr_nxt;

    // Interval is sampled only on the rise cycle; the current LFSR value is
    // used before the register steps.
    assign w_mask     = (16'd1 << rand_shift) - 16'd1;
    assign w_raw      = {1'b0, period} + {5'd0, (rand_en ? (r_lfsr & w_mask) : 16'd0)};
    assign w_interval = (w_raw < c_MIN_IV) ? c_MIN_IV : w_raw;
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_win_end  = (r_win == c_WIN_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_rise      = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_cnt == c_WIDTH) begin
                    w_fall      = 1'b1;
                    w_state_nxt = en ? S_LOW : S_IDLE;
                end
            end
            S_LOW: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_interval) begin
                    w_rise      = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_cnt holds the number of cycles elapsed since the most recent rise.
    always_ff @(posedge clk400M or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 21'd0;
            r_interval    <= c_MIN_IV;
            r_lfsr        <= c_SEED;
            r_out         <= 1'b0;
            r_pulse_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pulse_start <= w_rise;
            if (w_rise) begin
                r_cnt      <= 21'd1;
                r_interval <= w_interval;
                r_lfsr     <= w_lfsr_nxt;
                r_out      <= 1'b1;
            end else begin
                r_cnt <= (r_state == S_IDLE) ? 21'd0 : r_cnt + 21'd1;
                if (w_fall) begin
                    r_out <= 1'b0;
                end
            end
        end
    end

    // A rise on the last window cycle belongs to the following window.
    always_ff @(posedge clk400M or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_pcount    <= 17'd0;
            r_cnt_1ms   <= 17'd0;
            r_cnt_valid <= 1'b0;
        end else begin
            r_cnt_valid <= w_win_end;
            if (w_win_end) begin
                r_win     <= '0;
                r_cnt_1ms <= r_pcount;
                r_pcount  <= w_rise ? 17'd1 : 17'd0;
            end else begin
                r_win <= r_win + c_WW'(1);
                if (w_rise && (r_pcount != 17'h1FFFF)) begin
                    r_pcount <= r_pcount + 17'd1;
                end
            end
        end
    end

    assign sppm_out    = r_out;
    assign pulse_start = r_pulse_start;
    assign busy        = (r_state != S_IDLE);
    assign cnt_1ms     = r_cnt_1ms;
    assign cnt_valid   = r_cnt_valid;

endmodule
`default_nettype wire
